// File: rtl/ma_crossover_filter.sv
// Dual-window (short/long) moving-average filter with crossover buy/sell pulses.
// Latency: 1 cycle from an accepted sample to out_valid and the updated averages/flags.
// No backpressure: every in_valid cycle is accepted at full rate; gaps of any length are allowed.
//
// Ports:
//   clk, rst             single clock, synchronous active-high reset
//   in_valid, in_data    unsigned price sample stream
//   out_valid            results for the sample accepted last cycle
//   ma_short, ma_long    short_sum >> SHORT_LOG2, long_sum >> LONG_LOG2 (hold when idle)
//   short_full/long_full sticky "window filled since reset" flags
//   cross_up/cross_dn    single-cycle crossover pulses, only together with out_valid
module ma_crossover_filter #(
  parameter int DATA_W     = 8,
  parameter int SHORT_LOG2 = 2,
  parameter int LONG_LOG2  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] ma_short,
  output logic [DATA_W-1:0] ma_long,
  output logic              short_full,
  output logic              long_full,
  output logic              cross_up,
  output logic              cross_dn
);

  localparam int DEPTH  = 1 << LONG_LOG2;
  localparam int SWIN   = 1 << SHORT_LOG2;
  localparam int PTR_W  = LONG_LOG2;
  localparam int CNT_W  = LONG_LOG2 + 1;
  localparam int LSUM_W = DATA_W + LONG_LOG2;
  localparam int SSUM_W = DATA_W + SHORT_LOG2;

  typedef enum logic [1:0] {FILL, PRIME, TRACK} state_e;
  typedef enum logic [1:0] {REL_NONE, REL_ABOVE, REL_BELOW} rel_e;

  // Sample history; deliberately not cleared by reset.
  logic [DATA_W-1:0] hist_mem [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [LSUM_W-1:0] long_sum_q, long_sum_d;
  logic [SSUM_W-1:0] short_sum_q, short_sum_d;
  logic [DATA_W-1:0] old_long, old_short;
  logic [DATA_W-1:0] ma_short_d, ma_long_d;
  state_e            state_q, state_d;
  rel_e              rel_q, rel_d;
  logic              up_d, dn_d;

  logic              out_valid_q, short_full_q, long_full_q, cross_up_q, cross_dn_q;
  logic [DATA_W-1:0] ma_short_q, ma_long_q;

  always_ff @(posedge clk) begin
    if (in_valid && !rst) begin
      hist_mem[wr_ptr_q] <= in_data;
    end
  end

  // Running sums: retire the sample leaving each window once that window is full.
  // The slot at wr_ptr holds the sample from DEPTH accepts ago, which is exactly
  // the one leaving the long window.
  always_comb begin
    old_long    = (cnt_q == CNT_W'(DEPTH)) ? hist_mem[wr_ptr_q] : '0;
    old_short   = (cnt_q >= CNT_W'(SWIN)) ? hist_mem[wr_ptr_q - PTR_W'(SWIN)] : '0;
    long_sum_d  = long_sum_q;
    short_sum_d = short_sum_q;
    cnt_d       = cnt_q;
    wr_ptr_d    = wr_ptr_q;
    if (in_valid) begin
      // Subtract first so the intermediate never exceeds the window maximum.
      long_sum_d  = long_sum_q - LSUM_W'(old_long) + LSUM_W'(in_data);
      short_sum_d = short_sum_q - SSUM_W'(old_short) + SSUM_W'(in_data);
      cnt_d       = (cnt_q == CNT_W'(DEPTH)) ? cnt_q : cnt_q + 1'b1;
      wr_ptr_d    = wr_ptr_q + 1'b1;
    end
    // Always divide by the full window size, so averages read low while filling.
    ma_short_d = DATA_W'(short_sum_d >> SHORT_LOG2);
    ma_long_d  = DATA_W'(long_sum_d >> LONG_LOG2);
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      rel_q   <= REL_NONE;
    end else begin
      state_q <= state_d;
      rel_q   <= rel_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FILL:    if (in_valid && cnt_q == CNT_W'(DEPTH - 1)) state_d = PRIME;
      PRIME:   if (in_valid) state_d = TRACK;
      TRACK:   state_d = TRACK;
      default: state_d = FILL;
    endcase
  end

  // FSM: outputs (relation tracking and crossover pulses). The L-th sample is
  // still processed in FILL, so the first relation is recorded on the sample
  // after it; equal averages keep the previous relation.
  always_comb begin
    rel_d = rel_q;
    up_d  = 1'b0;
    dn_d  = 1'b0;
    if (in_valid && state_q != FILL) begin
      if (ma_short_d > ma_long_d) begin
        rel_d = REL_ABOVE;
      end else if (ma_short_d < ma_long_d) begin
        rel_d = REL_BELOW;
      end
      up_d = (rel_q == REL_BELOW) && (rel_d == REL_ABOVE);
      dn_d = (rel_q == REL_ABOVE) && (rel_d == REL_BELOW);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      cnt_q        <= '0;
      long_sum_q   <= '0;
      short_sum_q  <= '0;
      out_valid_q  <= 1'b0;
      ma_short_q   <= '0;
      ma_long_q    <= '0;
      short_full_q <= 1'b0;
      long_full_q  <= 1'b0;
      cross_up_q   <= 1'b0;
      cross_dn_q   <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      cnt_q       <= cnt_d;
      long_sum_q  <= long_sum_d;
      short_sum_q <= short_sum_d;
      out_valid_q <= in_valid;
      cross_up_q  <= up_d;
      cross_dn_q  <= dn_d;
      if (in_valid) begin
        ma_short_q   <= ma_short_d;
        ma_long_q    <= ma_long_d;
        short_full_q <= short_full_q | (cnt_d >= CNT_W'(SWIN));
        long_full_q  <= (cnt_d == CNT_W'(DEPTH));
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign ma_short   = ma_short_q;
  assign ma_long    = ma_long_q;
  assign short_full = short_full_q;
  assign long_full  = long_full_q;
  assign cross_up   = cross_up_q;
  assign cross_dn   = cross_dn_q;

endmodule

// File: tb/tb_ma_crossover_filter.sv
module tb_ma_crossover_filter;

  localparam int S = 4;
  localparam int L = 32;
  localparam int REL_NONE  = 0;
  localparam int REL_ABOVE = 1;
  localparam int REL_BELOW = 2;

  typedef struct packed {
    logic [7:0] ms;
    logic [7:0] ml;
    logic       sf;
    logic       lf;
    logic       up;
    logic       dn;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       out_valid;
  logic [7:0] ma_short, ma_long;
  logic       short_full, long_full, cross_up, cross_dn;

  int checks = 0;
  int failures = 0;

  obs_t sb[$];
  obs_t hold = '0;
  obs_t obs = '0;
  int   n_up = 0;
  int   n_dn = 0;
  logic iv_q = 1'b0;
  logic rst_q = 1'b0;

  // Reference model state: plain history list, total accepted count, relation.
  int hist[$];
  int nacc = 0;
  int rel = REL_NONE;

  ma_crossover_filter #(.DATA_W(8), .SHORT_LOG2(2), .LONG_LOG2(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .ma_short(ma_short), .ma_long(ma_long),
    .short_full(short_full), .long_full(long_full),
    .cross_up(cross_up), .cross_dn(cross_dn)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    iv_q  <= in_valid && !rst;
    rst_q <= rst;
  end

  // Monitor: pops the scoreboard on every out_valid, checks hold/idle otherwise.
  always @(negedge clk) begin
    obs_t cur, e;
    cur = '{ms: ma_short, ml: ma_long, sf: short_full, lf: long_full, up: cross_up, dn: cross_dn};
    if (rst_q) hold = '0;
    checks++;
    if (out_valid !== iv_q) begin
      failures++;
      $display("FAIL out_valid_timing got=%b exp=%b t=%0t", out_valid, iv_q, $time);
    end
    if (out_valid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL scoreboard_underflow got=out_valid exp=no_output t=%0t", $time);
      end else begin
        e = sb.pop_front();
        if (cur !== e) begin
          failures++;
          $display("FAIL sample_result got=ms%0d/ml%0d/sf%b/lf%b/up%b/dn%b exp=ms%0d/ml%0d/sf%b/lf%b/up%b/dn%b t=%0t",
                   cur.ms, cur.ml, cur.sf, cur.lf, cur.up, cur.dn,
                   e.ms, e.ml, e.sf, e.lf, e.up, e.dn, $time);
        end
        hold = e;
        hold.up = 1'b0;
        hold.dn = 1'b0;
      end
      obs = cur;
      if (cur.up === 1'b1) n_up++;
      if (cur.dn === 1'b1) n_dn++;
    end else begin
      checks++;
      if (cur !== hold) begin
        failures++;
        $display("FAIL idle_hold got=ms%0d/ml%0d/sf%b/lf%b/up%b/dn%b exp=ms%0d/ml%0d/sf%b/lf%b/up0/dn0 t=%0t",
                 cur.ms, cur.ml, cur.sf, cur.lf, cur.up, cur.dn,
                 hold.ms, hold.ml, hold.sf, hold.lf, $time);
      end
    end
  end

  task automatic model_push(input int x);
    int ss, ls, nbefore, ms, ml, nr;
    obs_t e;
    nbefore = nacc;
    hist.push_back(x);
    if (hist.size() > L) void'(hist.pop_front());
    nacc++;
    ss = 0;
    ls = 0;
    foreach (hist[i]) begin
      ls += hist[i];
      if (i >= hist.size() - S) ss += hist[i];
    end
    ms = ss / S;
    ml = ls / L;
    e = '0;
    e.ms = 8'(ms);
    e.ml = 8'(ml);
    e.sf = (nacc >= S);
    e.lf = (nacc >= L);
    // The relation is only tracked for samples arriving after the long window filled.
    if (nbefore >= L) begin
      nr = (ms > ml) ? REL_ABOVE : (ms < ml) ? REL_BELOW : rel;
      e.up = (rel == REL_BELOW) && (nr == REL_ABOVE);
      e.dn = (rel == REL_ABOVE) && (nr == REL_BELOW);
      rel = nr;
    end
    sb.push_back(e);
  endtask

  task automatic send(input int x);
    in_valid = 1'b1;
    in_data  = 8'(x);
    model_push(x);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reset with a coincident in_valid, which must be dropped.
  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'($urandom);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    hist.delete();
    nacc = 0;
    rel  = REL_NONE;
    n_up = 0;
    n_dn = 0;
  endtask

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic chk_zero_outputs(input string name);
    chk({name, "_valid"}, int'(out_valid), 0);
    chk({name, "_ma"}, int'({ma_short, ma_long}), 0);
    chk({name, "_flags"}, int'({short_full, long_full, cross_up, cross_dn}), 0);
  endtask

  initial begin
    int v;
    idle(2);
    do_reset();
    chk_zero_outputs("reset_state");

    // Single sample after reset.
    send(100);
    idle(1);
    chk("t1_ma_short", int'(obs.ms), 25);
    chk("t1_ma_long", int'(obs.ml), 3);
    chk("t1_flags", int'({obs.sf, obs.lf}), 0);

    // Steady fill at 100.
    do_reset();
    repeat (32) send(100);
    idle(1);
    chk("t2_ma", int'({obs.ms, obs.ml}), (100 << 8) | 100);
    chk("t2_long_full", int'(obs.lf), 1);
    chk("t2_pulses", n_up + n_dn, 0);

    // Full-scale input past the wrap point.
    do_reset();
    repeat (40) send(255);
    idle(1);
    chk("t3_ma", int'({obs.ms, obs.ml}), (255 << 8) | 255);
    chk("t3_pulses", n_up + n_dn, 0);

    // Rising crossover.
    do_reset();
    repeat (28) send(100);
    repeat (4) send(50);
    send(200);
    send(200);
    idle(1);
    chk("t4_ma", int'({obs.ms, obs.ml}), (125 << 8) | 100);
    chk("t4_cross_up", int'(obs.up), 1);
    chk("t4_n_up", n_up, 1);
    chk("t4_n_dn", n_dn, 0);

    // Falling crossover: exactly one pulse.
    repeat (10) send(50);
    idle(1);
    chk("t5_n_dn", n_dn, 1);
    chk("t5_n_up", n_up, 1);

    // Randomised random-walk prices with random gaps and a mid-run reset.
    do_reset();
    v = 128;
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset();
      v = v + int'($urandom_range(0, 60)) - 30;
      if (v < 0) v = 0;
      if (v > 255) v = 255;
      send(v);
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
    end
    idle(2);

    // Reset mid-stream, then sparse small samples.
    do_reset();
    repeat (10) send(int'($urandom_range(0, 255)));
    do_reset();
    chk_zero_outputs("t6_after_reset");
    for (int i = 0; i < 4; i++) begin
      send(8);
      idle(int'($urandom_range(1, 3)));
    end
    idle(1);
    chk("t6_ma_short", int'(obs.ms), 8);
    chk("t6_ma_long", int'(obs.ml), 1);
    chk("t6_flags", int'({obs.sf, obs.lf}), 2);

    chk("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
